pipelined_mult_vr: RTL and testbench

- Parametrised, pipelined Wallace/CSA multiplier with valid/ready handshake, per-operation signed/unsigned mode and a sideband tag that travels with each operand pair.
- Generalises the fixed 5x5 free-running multiplier to any operand width and pipeline depth.
- Adds backpressure, bubble tracking and flush.
- Sits between an operand-issue stage and a result consumer in the datapath.

---
 rtl/mult_pkg.sv | 51 +++++
 rtl/pipelined_mult_vr_csa.sv | 19 +
 rtl/pipelined_mult_vr.sv | 150 +++++++++++++++
 tb/tb_pipelined_mult_vr.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared helpers for the pipelined multiplier: CSA tree sizing, per-rank
// level allocation, Baugh-Wooley correction constant and parameter checks.
package mult_pkg;

  // Operand count left after one 3:2 level: every full group of three
  // collapses to two and any leftovers pass through.
  function automatic int ops_after_levels(int n, int levels);
    int m = n;
    for (int k = 0; k < levels; k++) m = 2 * (m / 3) + (m % 3);
    return m;
  endfunction

  // Number of 3:2 levels needed to bring n operands down to two.
  function automatic int csa_levels(int n);
    int m   = n;
    int cnt = 0;
    while (m > 2) begin
      m = 2 * (m / 3) + (m % 3);
      cnt++;
    end
    return cnt;
  endfunction

  // Levels placed in front of rank r (1-based) when 'total' levels are
  // spread over 'regions' ranks; the remainder lands on the earliest ranks.
  function automatic int rank_levels(int total, int regions, int r);
    return total / regions + (((r - 1) < (total % regions)) ? 1 : 0);
  endfunction

  // Global index of the first level feeding rank r (1-based).
  function automatic int rank_first_level(int total, int regions, int r);
    int first = 0;
    for (int q = 1; q < r; q++) first += rank_levels(total, regions, q);
    return first;
  endfunction

  // Constant added for a signed product: 2^w + 2^(2w-1).
  function automatic logic [63:0] bw_correction(int w);
    logic [63:0] c;
    c = '0;
    c[w]         = 1'b1;
    c[2 * w - 1] = 1'b1;
    return c;
  endfunction

  function automatic bit params_legal(int width, int stages, int tag_w);
    return (width >= 4) && (width <= 32) && (stages >= 2) && (stages <= 8) &&
           (tag_w >= 1) && (tag_w <= 16);
  endfunction

endpackage

// File: rtl/pipelined_mult_vr_csa.sv
// One row of full adders: reduces three vectors to a sum and a carry
// vector, the carry already shifted into its weight position.
module csa_3to2 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  // Carry out of the MSB falls outside the modular product width.
  assign sum   = x ^ y ^ z;
  assign carry = {(x[WIDTH-2:0] & y[WIDTH-2:0]) |
                  (x[WIDTH-2:0] & z[WIDTH-2:0]) |
                  (y[WIDTH-2:0] & z[WIDTH-2:0]), 1'b0};

endmodule

// File: rtl/pipelined_mult_vr.sv
// Pipelined Baugh-Wooley / CSA multiplier with valid-ready handshake,
// per-operation signed mode, sideband tag and synchronous flush.
module pipelined_mult_vr
  import mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int P_W     = 2 * WIDTH;
  localparam int N_PP    = WIDTH + 1;          // partial-product rows + correction row
  localparam int LEVELS  = csa_levels(N_PP);
  localparam int REGIONS = STAGES - 1;         // ranks that hold carry-save operands

  if (!params_legal(WIDTH, STAGES, TAG_W)) begin : g_bad_params
    $error("pipelined_mult_vr: WIDTH, STAGES or TAG_W out of range");
  end

  logic               advance;
  logic [P_W-1:0]     pp        [N_PP];
  logic [P_W-1:0]     lvl_in    [LEVELS][N_PP];
  logic [P_W-1:0]     lvl_out   [LEVELS][N_PP];
  logic [P_W-1:0]     region_in [REGIONS][N_PP];
  logic [P_W-1:0]     rank_d    [REGIONS][N_PP];
  logic [P_W-1:0]     rank_ops  [REGIONS][N_PP];
  logic [TAG_W-1:0]   rank_tag  [REGIONS];
  logic [REGIONS-1:0] rank_v;

  // The whole pipe moves together unless the output is full and unclaimed.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Partial products; in signed mode bits pairing exactly one sign bit are
  // inverted and the correction row is added.
  // NOTE: every row is given a default before its bits are set, so the
  // combinational block never holds a value and no latch is inferred.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = '0;
      for (int j = 0; j < WIDTH; j++)
        pp[i][i+j] = (a[j] & b[i]) ^ (is_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
    end
    pp[WIDTH] = is_signed ? P_W'(bw_correction(WIDTH)) : '0;
  end

  // Source operands of each rank's reduction region.
  for (genvar e = 0; e < N_PP; e++) begin : g_rin0
    assign region_in[0][e] = pp[e];
  end
  for (genvar r = 1; r < REGIONS; r++) begin : g_rin
    for (genvar e = 0; e < N_PP; e++) begin : g_e
      assign region_in[r][e] = rank_ops[r-1][e];
    end
  end

  // CSA levels, grouped by the rank they feed.
  for (genvar r = 0; r < REGIONS; r++) begin : g_region
    localparam int FIRST = rank_first_level(LEVELS, REGIONS, r + 1);
    localparam int CNT   = rank_levels(LEVELS, REGIONS, r + 1);
    for (genvar q = 0; q < CNT; q++) begin : g_level
      localparam int K = FIRST + q;
      localparam int N = ops_after_levels(N_PP, K);
      localparam int G = N / 3;
      for (genvar e = 0; e < N_PP; e++) begin : g_src
        if (q == 0) begin : g_from_rank
          assign lvl_in[K][e] = region_in[r][e];
        end else begin : g_from_level
          assign lvl_in[K][e] = lvl_out[K-1][e];
        end
      end
      for (genvar g = 0; g < G; g++) begin : g_csa
        csa_3to2 #(.WIDTH(P_W)) u_csa (
          .x    (lvl_in[K][3*g]),
          .y    (lvl_in[K][3*g+1]),
          .z    (lvl_in[K][3*g+2]),
          .sum  (lvl_out[K][2*g]),
          .carry(lvl_out[K][2*g+1])
        );
      end
      for (genvar e = 2 * G; e < N_PP; e++) begin : g_pass
        if (e - 2 * G < N % 3) begin : g_keep
          assign lvl_out[K][e] = lvl_in[K][e+G];
        end else begin : g_zero
          assign lvl_out[K][e] = '0;
        end
      end
    end
    for (genvar e = 0; e < N_PP; e++) begin : g_d
      if (CNT > 0) begin : g_reduced
        assign rank_d[r][e] = lvl_out[FIRST+CNT-1][e];
      end else begin : g_through
        assign rank_d[r][e] = region_in[r][e];
      end
    end
  end

  // Valid bits: cleared by reset and flush, shifted on advance.
  // NOTE: non-blocking assignments let every rank sample its predecessor's
  // pre-edge value, so the shift order inside the block does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rank_v    <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      rank_v    <= '0;
      out_valid <= 1'b0;
    end else if (advance) begin
      for (int r = REGIONS - 1; r > 0; r--) rank_v[r] <= rank_v[r-1];
      rank_v[0] <= in_valid;
      out_valid <= rank_v[REGIONS-1];
    end
  end

  // Data and tag ranks plus the final carry-propagate add; flush leaves them.
  // NOTE: the rank arrays are pipeline flops rather than a RAM, so they are
  // reset element by element to give a zero product and tag after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < REGIONS; r++) begin
        for (int e = 0; e < N_PP; e++) rank_ops[r][e] <= '0;
        rank_tag[r] <= '0;
      end
      product <= '0;
      out_tag <= '0;
    end else if (advance && !flush) begin
      for (int r = 0; r < REGIONS; r++)
        for (int e = 0; e < N_PP; e++) rank_ops[r][e] <= rank_d[r][e];
      rank_tag[0] <= in_tag;
      for (int r = 1; r < REGIONS; r++) rank_tag[r] <= rank_tag[r-1];
      product <= rank_ops[REGIONS-1][0] + rank_ops[REGIONS-1][1];
      out_tag <= rank_tag[REGIONS-1];
    end
  end

endmodule

// File: tb/tb_pipelined_mult_vr.sv
// Directed bench for pipelined_mult_vr (WIDTH=8, STAGES=4, TAG_W=4).
module tb_pipelined_mult_vr;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [3:0]  tag;
    logic [15:0] prod;
  } op_t;

  typedef struct {
    logic [15:0] prod;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        is_signed;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic [3:0]  out_tag;

  int   n_cmp   = 0;
  int   n_err   = 0;
  int   run_len = 0;
  int   max_run = 0;
  exp_t cur_exp;
  exp_t exp_q[$];
  op_t  tbl[16];

  pipelined_mult_vr #(.WIDTH(8), .STAGES(4), .TAG_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .is_signed(is_signed),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Present one op and leave it on the bus for exactly one accepting edge.
  task automatic issue(input logic [7:0] ai, input logic [7:0] bi, input logic si,
                       input logic [3:0] ti, input logic [15:0] pi);
    a = ai; b = bi; is_signed = si; in_tag = ti; in_valid = 1'b1;
    cur_exp.prod = pi;
    cur_exp.tag  = ti;
    for (int k = 0; k < 20 && !in_ready; k++) tick();
    if (!in_ready) check("issue_ready_timeout", 64'(in_ready), 64'd1);
    tick();
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: transfers and acceptances are both judged mid-cycle,
  // ahead of the edge that completes them.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_product", 64'(product), 64'(e.prod));
          check("sb_tag", 64'(out_tag), 64'(e.tag));
        end
      end else begin
        run_len = 0;
      end
      if (in_valid && in_ready && !flush) exp_q.push_back(cur_exp);
      if (flush) exp_q.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{8'h03, 8'h05, 1'b0, 4'd0,  16'h000F},
      '{8'h03, 8'h05, 1'b1, 4'd1,  16'h000F},
      '{8'hFF, 8'h02, 1'b0, 4'd2,  16'h01FE},
      '{8'hFF, 8'h02, 1'b1, 4'd3,  16'hFFFE},
      '{8'h10, 8'h10, 1'b0, 4'd4,  16'h0100},
      '{8'hF0, 8'h10, 1'b1, 4'd5,  16'hFF00},
      '{8'h00, 8'hAB, 1'b0, 4'd6,  16'h0000},
      '{8'h80, 8'h7F, 1'b1, 4'd7,  16'hC080},
      '{8'h80, 8'h80, 1'b0, 4'd8,  16'h4000},
      '{8'hFF, 8'hFF, 1'b1, 4'd9,  16'h0001},
      '{8'h12, 8'h34, 1'b0, 4'd10, 16'h03A8},
      '{8'hFE, 8'h03, 1'b1, 4'd11, 16'hFFFA},
      '{8'hAA, 8'h55, 1'b0, 4'd12, 16'h3872},
      '{8'h81, 8'h81, 1'b1, 4'd13, 16'h3F01},
      '{8'h0F, 8'hF0, 1'b0, 4'd14, 16'h0E10},
      '{8'h7F, 8'h7F, 1'b1, 4'd15, 16'h3F01}
    };
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; is_signed = 1'b0; in_tag = '0;
    cur_exp.prod = '0; cur_exp.tag = '0;

    // Reset state.
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    #22 rst = 1'b0;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Unsigned 255*255, latency STAGES-1 edges.
    issue(8'hFF, 8'hFF, 1'b0, 4'd3, 16'hFE01);
    idle();
    tick(); check("lat_n1_valid", 64'(out_valid), 64'd0);
    tick(); check("lat_n2_valid", 64'(out_valid), 64'd0);
    tick(); check("lat_n3_valid", 64'(out_valid), 64'd1);
    check("lat_product", 64'(product), 64'hFE01);
    check("lat_tag", 64'(out_tag), 64'd3);
    tick(); check("lat_bubble", 64'(out_valid), 64'd0);

    // Signed corner operands, back to back.
    issue(8'h80, 8'h80, 1'b1, 4'd1, 16'h4000);
    issue(8'hFF, 8'h01, 1'b1, 4'd2, 16'hFFFF);
    issue(8'h7F, 8'h80, 1'b1, 4'd4, 16'hC080);
    idle();
    tick(); check("s0_valid", 64'(out_valid), 64'd1);
    check("s0_product", 64'(product), 64'h4000);
    check("s0_tag", 64'(out_tag), 64'd1);
    tick(); check("s1_valid", 64'(out_valid), 64'd1);
    check("s1_product", 64'(product), 64'hFFFF);
    check("s1_tag", 64'(out_tag), 64'd2);
    tick(); check("s2_valid", 64'(out_valid), 64'd1);
    check("s2_product", 64'(product), 64'hC080);
    check("s2_tag", 64'(out_tag), 64'd4);
    drain();

    // Sixteen mixed-mode ops streamed with out_ready held high.
    max_run = 0;
    for (int i = 0; i < 16; i++) issue(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].tag, tbl[i].prod);
    idle();
    drain();
    check("stream_run_len", 64'(max_run), 64'd16);

    // Backpressure: stall with op 2 at the output for three cycles.
    for (int i = 0; i < 6; i++) issue(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].tag, tbl[i].prod);
    idle();
    out_ready = 1'b0;
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_product", 64'(product), 64'(tbl[2].prod));
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_hold_valid", 64'(out_valid), 64'd1);
      check("stall_hold_product", 64'(product), 64'(tbl[2].prod));
      check("stall_hold_tag", 64'(out_tag), 64'd2);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    drain();

    // Flush with three ops in flight and a fourth offered alongside.
    for (int i = 7; i < 10; i++) issue(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].tag, tbl[i].prod);
    a = tbl[10].a; b = tbl[10].b; is_signed = tbl[10].s; in_tag = tbl[10].tag;
    cur_exp.prod = tbl[10].prod; cur_exp.tag = tbl[10].tag;
    flush = 1'b1;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0;
    idle();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("flush_quiet", 64'(out_valid), 64'd0);
    end
    issue(tbl[11].a, tbl[11].b, tbl[11].s, tbl[11].tag, tbl[11].prod);
    idle();
    tick(); tick();
    check("post_flush_early", 64'(out_valid), 64'd0);
    tick();
    check("post_flush_valid", 64'(out_valid), 64'd1);
    check("post_flush_product", 64'(product), 64'hFFFA);
    check("post_flush_tag", 64'(out_tag), 64'd11);
    drain();

    // Asynchronous reset with ops in flight and one at the output.
    for (int i = 13; i < 16; i++) issue(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].tag, tbl[i].prod);
    idle();
    tick();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_product", 64'(product), 64'd0);
    check("async_rst_tag", 64'(out_tag), 64'd0);
    tick(); tick();
    check("rst_held_valid", 64'(out_valid), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("rst_release_in_ready", 64'(in_ready), 64'd1);
    tick();
    issue(tbl[12].a, tbl[12].b, tbl[12].s, tbl[12].tag, tbl[12].prod);
    idle();
    tick(); tick();
    check("resume_early", 64'(out_valid), 64'd0);
    tick();
    check("resume_valid", 64'(out_valid), 64'd1);
    check("resume_product", 64'(product), 64'h3872);
    check("resume_tag", 64'(out_tag), 64'd12);
    drain();
    tick(); tick();
    check("final_idle", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
